// File: rtl/env_cls_pkg.sv
// Shared types and default constants for the environment frame sequencer.
// Contents:
//   seq_state_e  - sequencer FSM states (collect / dispatch / wait for class)
//   N_CH_DEF, DW_DEF, CLASS_W_DEF - default channel count, sample and class widths
//   CH_W         - width of the incoming channel index
package env_cls_pkg;

    localparam int unsigned N_CH_DEF    = 4;
    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned CLASS_W_DEF = 5;
    localparam int unsigned CH_W        = 4;

    typedef enum logic [1:0] {
        StCollect  = 2'd0,
        StDispatch = 2'd1,
        StWaitCls  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/env_frame_sequencer_if.sv
// Bus bundle between the sample source / classifier side and the frame sequencer.
// Optional macro ENV_FRAME_CNT_EN adds the 16-bit frame_cnt output.
// Signals:
//   s_valid, s_ch, s_data, s_ready          - sample stream from the I2C readout
//   frame_data, frame_valid, frame_ready    - frame handshake towards the classifier
//   cls_valid, cls_in                       - classifier result
//   class_out, class_valid, class_changed   - filtered committed class
//   ch_err, timeout_err                     - single-cycle error pulses
//   frame_cnt (ENV_FRAME_CNT_EN only)       - count of dispatched frames
// Modports: master = environment side (drives samples/results), slave = sequencer.
interface env_frame_sequencer_if
    import env_cls_pkg::*;
#(
    parameter int unsigned N_CH    = N_CH_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned CLASS_W = CLASS_W_DEF
) ();

    logic                 s_valid;
    logic [CH_W-1:0]      s_ch;
    logic [DW-1:0]        s_data;
    logic                 s_ready;
    logic [N_CH*DW-1:0]   frame_data;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 cls_valid;
    logic [CLASS_W-1:0]   cls_in;
    logic [CLASS_W-1:0]   class_out;
    logic                 class_valid;
    logic                 class_changed;
    logic                 ch_err;
    logic                 timeout_err;
`ifdef ENV_FRAME_CNT_EN
    logic [15:0]          frame_cnt;
`endif

    modport master (
        output s_valid, s_ch, s_data, frame_ready, cls_valid, cls_in,
        input  s_ready, frame_data, frame_valid, class_out, class_valid, class_changed,
               ch_err, timeout_err
`ifdef ENV_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

    modport slave (
        input  s_valid, s_ch, s_data, frame_ready, cls_valid, cls_in,
        output s_ready, frame_data, frame_valid, class_out, class_valid, class_changed,
               ch_err, timeout_err
`ifdef ENV_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

endinterface

// File: rtl/class_hysteresis.sv
// Consecutive-agreement filter for classifier results. A new class is only
// committed after STABLE_CNT identical results in a row.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   in_valid       - a classifier result is presented this cycle
//   in_class       - classifier result
//   class_out      - committed class
//   class_valid    - at least one class committed since reset
//   class_changed  - one-cycle pulse when class_out updates
module class_hysteresis #(
    parameter int unsigned CLASS_W    = 5,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [CLASS_W-1:0] in_class,
    output logic [CLASS_W-1:0] class_out,
    output logic               class_valid,
    output logic               class_changed
);

    localparam logic [3:0] StableCnt = 4'(STABLE_CNT);

    logic [CLASS_W-1:0] cand_q, cand_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        class_d   = class_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (in_valid) begin
            if (in_class == cand_q) begin
                // Saturate so a long run of agreement never wraps back below the threshold.
                cnt_d = (cnt_q >= StableCnt) ? StableCnt : cnt_q + 4'd1;
            end else begin
                cand_d = in_class;
                cnt_d  = 4'd1;
            end
            if ((cnt_d == StableCnt) && ((cand_d != class_q) || !valid_q)) begin
                class_d   = cand_d;
                valid_d   = 1'b1;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q    <= '0;
            cnt_q     <= 4'd0;
            class_q   <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            class_q   <= class_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign class_out     = class_q;
    assign class_valid   = valid_q;
    assign class_changed = changed_q;

endmodule

// File: rtl/env_frame_sequencer.sv
// Environment frame sequencer: gathers one sample per channel into a frame,
// offers the frame to the classifier over valid/ready, waits (with timeout)
// for the result and passes it through a hysteresis filter.
// Optional macro ENV_FRAME_CNT_EN adds a 16-bit wrapping frame handshake counter.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - env_frame_sequencer_if.slave: sample stream, frame handshake,
//          classifier result, committed class and error pulses
module env_frame_sequencer
    import env_cls_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned CLASS_W    = CLASS_W_DEF,
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    env_frame_sequencer_if.slave  bus
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TimeoutLast = TCNT_W'(TIMEOUT - 1);

    seq_state_e              state_q, state_d;
    logic [N_CH-1:0]         seen_q, seen_d;
    logic [N_CH-1:0][DW-1:0] frame_q, frame_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic                    ch_err_q, ch_err_d;
    logic                    tout_q, tout_d;

    logic                    s_accept;
    logic                    ch_ok;
    logic                    cls_take;
    logic [CLASS_W-1:0]      hyst_class;
    logic                    hyst_valid;
    logic                    hyst_changed;

    assign s_accept = bus.s_valid && (state_q == StCollect);
    assign ch_ok    = 32'(bus.s_ch) < N_CH;
    assign cls_take = bus.cls_valid && (state_q == StWaitCls);

    // Datapath: frame capture, seen mask, timeout counter, error pulses.
    always_comb begin
        seen_d   = seen_q;
        frame_d  = frame_q;
        tcnt_d   = tcnt_q;
        ch_err_d = 1'b0;
        tout_d   = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (s_accept) begin
                    if (ch_ok) begin
                        for (int unsigned k = 0; k < N_CH; k++) begin
                            if (bus.s_ch == CH_W'(k)) begin
                                frame_d[k] = bus.s_data;
                                seen_d[k]  = 1'b1;
                            end
                        end
                    end else begin
                        ch_err_d = 1'b1;
                    end
                end
            end
            StDispatch: begin
                if (bus.frame_ready) begin
                    tcnt_d = '0;
                end
            end
            StWaitCls: begin
                tcnt_d = tcnt_q + 1'b1;
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (bus.cls_valid) begin
                    seen_d = '0;
                end else if (tcnt_q == TimeoutLast) begin
                    seen_d = '0;
                    tout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: begin
                // seen_d already includes the sample accepted this cycle.
                if (s_accept && (&seen_d)) begin
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                if (bus.frame_ready) begin
                    state_d = StWaitCls;
                end
            end
            StWaitCls: begin
                if (bus.cls_valid || (tcnt_q == TimeoutLast)) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // FSM / registered outputs. s_ready is gated by rst so every output reads 0 in reset.
    always_comb begin
        bus.s_ready       = (state_q == StCollect) && !rst;
        bus.frame_valid   = (state_q == StDispatch);
        bus.frame_data    = frame_q;
        bus.ch_err        = ch_err_q;
        bus.timeout_err   = tout_q;
        bus.class_out     = hyst_class;
        bus.class_valid   = hyst_valid;
        bus.class_changed = hyst_changed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q   <= '0;
            frame_q  <= '0;
            tcnt_q   <= '0;
            ch_err_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            tcnt_q   <= tcnt_d;
            ch_err_q <= ch_err_d;
            tout_q   <= tout_d;
        end
    end

`ifdef ENV_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if ((state_q == StDispatch) && bus.frame_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

    class_hysteresis #(
        .CLASS_W    (CLASS_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_hyst (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (cls_take),
        .in_class      (bus.cls_in),
        .class_out     (hyst_class),
        .class_valid   (hyst_valid),
        .class_changed (hyst_changed)
    );

endmodule

// File: tb/tb_env_frame_sequencer.sv
// Self-checking bench for env_frame_sequencer (default parameters).
module tb_env_frame_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    env_frame_sequencer_if #(.N_CH(4), .DW(16), .CLASS_W(5)) bus ();

    env_frame_sequencer #(
        .N_CH       (4),
        .DW         (16),
        .CLASS_W    (5),
        .STABLE_CNT (3),
        .TIMEOUT    (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s_valid;
        logic [3:0]  s_ch;
        logic [15:0] s_data;
        logic        frame_ready;
        logic        cls_valid;
        logic [4:0]  cls_in;
        logic        e_s_ready;
        logic        e_frame_valid;
        logic        e_ch_err;
        logic        chk_frame;
        logic [63:0] e_frame;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, logic [3:0] ch, logic [15:0] d, logic fr, logic cv,
                                logic [4:0] ci, logic esr, logic efv, logic ece, logic cf,
                                logic [63:0] ef);
        vec_t v;
        v.s_valid = sv; v.s_ch = ch; v.s_data = d; v.frame_ready = fr;
        v.cls_valid = cv; v.cls_in = ci; v.e_s_ready = esr; v.e_frame_valid = efv;
        v.e_ch_err = ece; v.chk_frame = cf; v.e_frame = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.s_valid = 1'b0; bus.s_ch = 4'd0; bus.s_data = 16'd0;
        bus.frame_ready = 1'b0; bus.cls_valid = 1'b0; bus.cls_in = 5'd0;
    endtask

    // All tasks start and end at posedge+1.
    task automatic send_sample(input logic [3:0] ch, input logic [15:0] d);
        bus.s_valid = 1'b1; bus.s_ch = ch; bus.s_data = d;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic feed_frame(input logic [15:0] base);
        for (int k = 0; k < 4; k++) send_sample(4'(k), base + 16'(k));
    endtask

    task automatic dispatch(input string name);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        chk({name, "_fv"}, 64'(bus.frame_valid), 64'd1);
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
    endtask

    task automatic classify(input logic [4:0] c);
        bus.cls_valid = 1'b1; bus.cls_in = c;
        @(posedge clk); #1;
        bus.cls_valid = 1'b0;
    endtask

    logic [4:0] hseq[6]  = '{5'd2, 5'd2, 5'd5, 5'd2, 5'd2, 5'd2};
    logic [4:0] hcls[6]  = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd2};
    logic       hchg[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int k;
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;

        // Vectors: inputs for one cycle, outputs expected during that same cycle.
        vecs.push_back(mk(1, 0, 16'h0100, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0200, 0, 1, 5, 1, 0, 0, 0, 0)); // stray cls_valid ignored
        vecs.push_back(mk(1, 2, 16'h0300, 1, 0, 0, 1, 0, 0, 0, 0)); // stray frame_ready ignored
        vecs.push_back(mk(1, 3, 16'h0400, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 1, 0, 1, 64'h0400_0300_0200_0100));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h1111, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h2222, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 16'hDEAD, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0AAA, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 16'h0BBB, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 16'h0CCC, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 1, 0, 1, 64'h0CCC_0BBB_2222_0AAA));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0));

        // Reset state.
        #12;
        chk("reset_outs", {60'd0, bus.s_ready, bus.frame_valid, bus.ch_err, bus.timeout_err},
            64'd0);
        chk("reset_class", {57'd0, bus.class_out, bus.class_valid, bus.class_changed}, 64'd0);
        chk("reset_frame", bus.frame_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.s_valid = vecs[i].s_valid; bus.s_ch = vecs[i].s_ch;
            bus.s_data = vecs[i].s_data; bus.frame_ready = vecs[i].frame_ready;
            bus.cls_valid = vecs[i].cls_valid; bus.cls_in = vecs[i].cls_in;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {53'd0, bus.s_ready, bus.frame_valid, bus.ch_err, bus.timeout_err,
                 bus.class_valid, bus.class_changed, bus.class_out},
                {53'd0, vecs[i].e_s_ready, vecs[i].e_frame_valid, vecs[i].e_ch_err,
                 8'd0});
            if (vecs[i].chk_frame) chk($sformatf("vec%0d_frame", i), bus.frame_data,
                                       vecs[i].e_frame);
            @(posedge clk); #1;
        end
        idle_inputs();

        // Backpressure: frame held for 20 cycles, accepted on the 21st.
        feed_frame(16'h3000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d", i), {bus.frame_valid, bus.s_ready, bus.frame_data[61:0]},
                {1'b1, 1'b0, 62'h3003_3002_3001_3000});
            @(posedge clk); #1;
        end
        dispatch("hold_acc");
        @(negedge clk);
        chk("hold_wait", {62'd0, bus.s_ready, bus.frame_valid}, 64'd0);
        bus.cls_valid = 1'b1; bus.cls_in = 5'd5;
        @(posedge clk); #1;
        bus.cls_valid = 1'b0;
        @(negedge clk);
        chk("commit5", {56'd0, bus.s_ready, bus.class_valid, bus.class_changed, bus.class_out},
            {56'd0, 1'b1, 1'b1, 1'b1, 5'd5});
        @(posedge clk); #1;
        @(negedge clk);
        chk("commit5_pulse", 64'(bus.class_changed), 64'd0);
        @(posedge clk); #1;

        // Hysteresis: 2,2,5,2,2,2.
        for (int i = 0; i < 6; i++) begin
            feed_frame(16'h4000);
            dispatch($sformatf("hyst%0d", i));
            classify(hseq[i]);
            @(negedge clk);
            chk($sformatf("hyst%0d", i), {57'd0, bus.class_out, bus.class_valid,
                bus.class_changed}, {57'd0, hcls[i], 1'b1, hchg[i]});
            @(posedge clk); #1;
        end

        // Timeout: no result after dispatch.
        feed_frame(16'h5000);
        dispatch("tout");
        k = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (bus.timeout_err) begin
                k = i;
                break;
            end
        end
        chk("tout_latency", 64'(k), 64'd1025);
        chk("tout_state", {57'd0, bus.s_ready, bus.class_out, bus.class_valid},
            {57'd0, 1'b1, 5'd2, 1'b1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("tout_pulse", 64'(bus.timeout_err), 64'd0);
        @(posedge clk); #1;

        // Result on the exact expiry cycle wins.
        for (int i = 0; i < 2; i++) begin
            feed_frame(16'h6000);
            dispatch("pre7");
            classify(5'd7);
        end
        feed_frame(16'h6000);
        dispatch("expiry");
        repeat (1023) begin
            @(posedge clk); #1;
        end
        classify(5'd7);
        @(negedge clk);
        chk("expiry_win", {56'd0, bus.timeout_err, bus.s_ready, bus.class_changed, bus.class_out},
            {56'd0, 1'b0, 1'b1, 1'b1, 5'd7});
        @(posedge clk); #1;
        @(negedge clk);
        chk("expiry_no_tout", 64'(bus.timeout_err), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset during DISPATCH.
        feed_frame(16'h7000);
        rst = 1'b1;
        #1;
        chk("rst_async", {55'd0, bus.frame_valid, bus.s_ready, bus.class_valid, bus.class_out,
            bus.frame_data[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_sample(4'd0, 16'h0011);
        send_sample(4'd1, 16'h0022);
        send_sample(4'd2, 16'h0033);
        @(negedge clk);
        chk("rst_seen_clr", {62'd0, bus.frame_valid, bus.s_ready}, 64'd1);
        @(posedge clk); #1;
        send_sample(4'd3, 16'h0044);
        @(negedge clk);
        chk("rst_resume", bus.frame_data, 64'h0044_0033_0022_0011);
        @(posedge clk); #1;
        dispatch("rst_disp");
`ifdef ENV_FRAME_CNT_EN
        @(negedge clk);
        chk("frame_cnt", 64'(bus.frame_cnt), 64'd1);
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
